// File: rtl/fir_sample_feeder.sv
// Host-stream to FIR sample feeder: FIFO-buffers float32 samples, presents one per FIR
// `next` request, raises fir_stop at end of stream or tap limit, and flags underruns.
module fir_sample_feeder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_SAMPLES = 145
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fir_next,
  output logic [DATA_W-1:0] fir_in,
  output logic              fir_stop,
  output logic [8:0]        sample_count,
  output logic              underrun
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [8:0] MAX_CNT = 9'(MAX_SAMPLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              last_seen_r;
  logic              fir_next_q_r;
  state_t            state_r;

  state_t            state_nxt_s;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              req_s;
  logic [DATA_W-1:0] fir_in_nxt_s;
  logic              stop_nxt_s;
  logic [8:0]        count_nxt_s;
  logic              underrun_nxt_s;

  // Status is decoded from registered pointers only, so a same-cycle push never bypasses.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign s_ready = rst && !full_s && !last_seen_r;
  assign push_s  = s_valid && s_ready;
  // FIR holds `next` high through its own reset, so only a rising edge is a request.
  assign req_s   = fir_next && !fir_next_q_r;

  // Next-state and next-output decode for the delivery FSM.
  always_comb begin
    state_nxt_s    = state_r;
    pop_s          = 1'b0;
    fir_in_nxt_s   = fir_in;
    stop_nxt_s     = fir_stop;
    count_nxt_s    = sample_count;
    underrun_nxt_s = underrun;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          fir_in_nxt_s = mem_r[rd_ptr_r[AW-1:0]];
          count_nxt_s  = 9'd1;
          state_nxt_s  = RUN;
        end else begin
          fir_in_nxt_s = '0;
        end
      end
      RUN: begin
        if (req_s) begin
          if (sample_count >= MAX_CNT) begin
            fir_in_nxt_s = '0;
            stop_nxt_s   = 1'b1;
            state_nxt_s  = DRAIN;
          end else if (!empty_s) begin
            pop_s        = 1'b1;
            fir_in_nxt_s = mem_r[rd_ptr_r[AW-1:0]];
            count_nxt_s  = sample_count + 9'd1;
          end else if (last_seen_r) begin
            fir_in_nxt_s = '0;
            stop_nxt_s   = 1'b1;
            state_nxt_s  = DRAIN;
          end else begin
            fir_in_nxt_s   = '0;
            underrun_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        fir_in_nxt_s = '0;
        stop_nxt_s   = 1'b1;
      end
      default: begin
        state_nxt_s  = IDLE;
        fir_in_nxt_s = '0;
        stop_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, output and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      last_seen_r  <= 1'b0;
      fir_next_q_r <= 1'b1;
      fir_in       <= '0;
      fir_stop     <= 1'b0;
      sample_count <= 9'd0;
      underrun     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fir_next_q_r <= fir_next;
      fir_in       <= fir_in_nxt_s;
      fir_stop     <= stop_nxt_s;
      sample_count <= count_nxt_s;
      underrun     <= underrun_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      if (push_s && s_last) begin
        last_seen_r <= 1'b1;
      end
    end
  end

  // Sample storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= s_data;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for fir_sample_feeder: reset, basic stream, FIFO full,
// underrun, tap-limit stop and asynchronous mid-stream reset.
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        fir_next = 1'b0;
  logic [31:0] fir_in;
  logic        fir_stop;
  logic [8:0]  sample_count;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  fir_sample_feeder #(.DATA_W(32), .DEPTH(16), .MAX_SAMPLES(145)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .fir_next(fir_next), .fir_in(fir_in), .fir_stop(fir_stop),
    .sample_count(sample_count), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse();
    fir_next = 1'b1;
    tick();
    fir_next = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; fir_next = 1'b0;
    tick();
    @(posedge clk); #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b1; s_data = 32'h3F800000;
    for (int i = 0; i < 6; i++) begin
      fir_next = i[0];
      tick();
    end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    checks++; if (fir_in !== 32'h0) begin errors++; $display("FAIL reset_fir_in: got %h want 0", fir_in); end
    checks++; if (fir_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b want 0", fir_stop); end
    checks++; if (sample_count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    s_valid = 1'b0; fir_next = 1'b0;
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic(input string tag);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL %s_ready0: got %b want 1", tag, s_ready); end
    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b0);
    push(32'h40400000, 1'b1);
    tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_last: got %b want 0", tag, s_ready); end
    checks++; if (fir_in !== 32'h3F800000) begin errors++; $display("FAIL %s_idle_load: got %h want 3f800000", tag, fir_in); end
    checks++; if (sample_count !== 9'd1) begin errors++; $display("FAIL %s_count1: got %0d want 1", tag, sample_count); end
    pulse();
    checks++; if (fir_in !== 32'h40000000) begin errors++; $display("FAIL %s_second: got %h want 40000000", tag, fir_in); end
    pulse();
    checks++; if (fir_in !== 32'h40400000) begin errors++; $display("FAIL %s_third: got %h want 40400000", tag, fir_in); end
    checks++; if (fir_stop !== 1'b0) begin errors++; $display("FAIL %s_stop_early: got %b want 0", tag, fir_stop); end
    pulse();
    checks++; if (fir_stop !== 1'b1) begin errors++; $display("FAIL %s_stop: got %b want 1", tag, fir_stop); end
    checks++; if (fir_in !== 32'h0) begin errors++; $display("FAIL %s_pad: got %h want 0", tag, fir_in); end
    checks++; if (sample_count !== 9'd3) begin errors++; $display("FAIL %s_count3: got %0d want 3", tag, sample_count); end
    pulse();
    checks++; if (fir_stop !== 1'b1 || fir_in !== 32'h0 || sample_count !== 9'd3) begin
      errors++; $display("FAIL %s_drain_hold: got stop=%b in=%h cnt=%0d want 1/0/3", tag, fir_stop, fir_in, sample_count);
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL %s_underrun: got %b want 0", tag, underrun); end
  endtask

  task automatic test_fifo_full();
    int accepted = 0;
    // 16 words fill the FIFO plus one already loaded into fir_in by IDLE.
    for (int i = 0; i < 17; i++) begin
      if (s_ready === 1'b1) accepted++;
      push(32'h10000000 + 32'(i), 1'b0);
    end
    checks++; if (accepted != 17) begin errors++; $display("FAIL full_accepted: got %0d want 17", accepted); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", s_ready); end
    checks++; if (fir_in !== 32'h10000000) begin errors++; $display("FAIL full_head: got %h want 10000000", fir_in); end
    fir_next = 1'b1;
    tick();
    fir_next = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", s_ready); end
    checks++; if (fir_in !== 32'h10000001) begin errors++; $display("FAIL full_next: got %h want 10000001", fir_in); end
    checks++; if (sample_count !== 9'd2) begin errors++; $display("FAIL full_count: got %0d want 2", sample_count); end
  endtask

  task automatic test_underrun();
    push(32'h3F800000, 1'b0);
    tick();
    checks++; if (fir_in !== 32'h3F800000) begin errors++; $display("FAIL ur_load: got %h want 3f800000", fir_in); end
    pulse();
    pulse();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", underrun); end
    checks++; if (fir_in !== 32'h0) begin errors++; $display("FAIL ur_fir_in: got %h want 0", fir_in); end
    checks++; if (sample_count !== 9'd1) begin errors++; $display("FAIL ur_count: got %0d want 1", sample_count); end
    checks++; if (fir_stop !== 1'b0) begin errors++; $display("FAIL ur_stop: got %b want 0", fir_stop); end
    push(32'h40000000, 1'b0);
    pulse();
    checks++; if (fir_in !== 32'h40000000) begin errors++; $display("FAIL ur_recover: got %h want 40000000", fir_in); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    checks++; if (sample_count !== 9'd2) begin errors++; $display("FAIL ur_count2: got %0d want 2", sample_count); end
  endtask

  task automatic test_limit();
    int sent = 0;
    logic got_stop = 1'b0;
    logic acc;
    logic [31:0] prev = 32'h0;
    for (int c = 0; c < 2000 && !got_stop; c++) begin
      s_valid  = (sent < 200);
      s_data   = 32'h40000000 + 32'(sent);
      s_last   = (sent == 199);
      fir_next = (c % 2 == 1);
      acc = s_valid && s_ready;
      tick();
      if (acc) sent++;
      if (fir_stop === 1'b1) got_stop = 1'b1;
      else if (fir_in !== 32'h0) prev = fir_in;
    end
    s_valid = 1'b0; s_last = 1'b0; fir_next = 1'b0;
    tick();
    checks++; if (got_stop !== 1'b1) begin errors++; $display("FAIL limit_stop_timeout: got %b want 1", got_stop); end
    checks++; if (sample_count !== 9'd145) begin errors++; $display("FAIL limit_count: got %0d want 145", sample_count); end
    checks++; if (fir_in !== 32'h0) begin errors++; $display("FAIL limit_pad: got %h want 0", fir_in); end
    checks++; if (prev !== 32'h40000090) begin errors++; $display("FAIL limit_last_sample: got %h want 40000090", prev); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL limit_underrun: got %b want 0", underrun); end
    pulse();
    pulse();
    checks++; if (sample_count !== 9'd145 || fir_stop !== 1'b1) begin
      errors++; $display("FAIL limit_saturate: got cnt=%0d stop=%b want 145/1", sample_count, fir_stop);
    end
  endtask

  task automatic test_async_reset();
    push(32'h40A00000, 1'b0);
    push(32'h40C00000, 1'b0);
    pulse();
    push(32'h40E00000, 1'b0);
    checks++; if (fir_in !== 32'h40C00000) begin errors++; $display("FAIL ar_pre: got %h want 40c00000", fir_in); end
    #3 rst = 1'b0;
    #1;
    checks++; if (fir_in !== 32'h0) begin errors++; $display("FAIL ar_fir_in: got %h want 0", fir_in); end
    checks++; if (sample_count !== 9'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", sample_count); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ar_ready: got %b want 0", s_ready); end
    checks++; if (fir_stop !== 1'b0) begin errors++; $display("FAIL ar_stop: got %b want 0", fir_stop); end
    tick();
    @(posedge clk); #3;
    rst = 1'b1;
    tick();
    test_basic("restart");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    do_reset();
    test_fifo_full();
    do_reset();
    test_underrun();
    do_reset();
    test_limit();
    do_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
